// File: rtl/hp300_cegen.sv
// Multi-channel programmable clock-enable / divided-clock generator.
// Each channel divides by (act+1), with a shadow divisor applied at period boundaries.
module hp300_cegen #(
  parameter int                     NCH      = 2,
  parameter int                     DIVW     = 8,
  parameter logic [NCH*DIVW-1:0]    DIV_INIT = {8'd1, 8'd0}
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NCH-1:0]        en_i,
  input  logic [NCH*DIVW-1:0]   div_i,
  input  logic [NCH-1:0]        div_load_i,
  input  logic                  sync_i,
  output logic [NCH-1:0]        ce_o,
  output logic [NCH-1:0]        clk_o,
  output logic [NCH-1:0]        pending_o
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIVW-1:0] r_cnt, r_act, r_shd;
    logic            r_pend, r_ce, r_clk;
    logic [DIVW-1:0] w_cnt_nx, w_act_nx, w_shd_nx, w_div;
    logic            w_pend_nx, w_ce_nx, w_clk_nx, w_load, w_wrap, w_boundary;

    assign w_div      = div_i[k*DIVW +: DIVW];
    assign w_load     = div_load_i[k];
    assign w_wrap     = en_i[k] && (r_cnt == r_act);
    // A load lands directly in act whenever the current period cannot be disturbed.
    assign w_boundary = sync_i || w_wrap || !en_i[k];

    // Next-state for counter, outputs and divisor registers of this channel
    always_comb begin
      w_cnt_nx  = r_cnt;
      w_act_nx  = r_act;
      w_shd_nx  = r_shd;
      w_pend_nx = r_pend;
      w_ce_nx   = 1'b0;
      w_clk_nx  = r_clk;

      if (sync_i) begin
        w_cnt_nx = {DIVW{1'b0}};
        w_clk_nx = 1'b0;
      end else if (w_wrap) begin
        w_cnt_nx = {DIVW{1'b0}};
        w_ce_nx  = 1'b1;
        w_clk_nx = ~r_clk;
      end else if (en_i[k]) begin
        w_cnt_nx = r_cnt + DIVW'(1);
      end else begin
        w_cnt_nx = r_cnt;
      end

      if (w_load && w_boundary) begin
        w_act_nx  = w_div;
        w_shd_nx  = w_div;
        w_pend_nx = 1'b0;
      end else if (w_load) begin
        w_shd_nx  = w_div;
        w_pend_nx = 1'b1;
      end else if (r_pend && (sync_i || w_wrap)) begin
        w_act_nx  = r_shd;
        w_pend_nx = 1'b0;
      end else begin
        w_pend_nx = r_pend;
      end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_cnt  <= {DIVW{1'b0}};
        r_act  <= DIV_INIT[k*DIVW +: DIVW];
        r_shd  <= DIV_INIT[k*DIVW +: DIVW];
        r_pend <= 1'b0;
        r_ce   <= 1'b0;
        r_clk  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nx;
        r_act  <= w_act_nx;
        r_shd  <= w_shd_nx;
        r_pend <= w_pend_nx;
        r_ce   <= w_ce_nx;
        r_clk  <= w_clk_nx;
      end
    end

    assign ce_o[k]      = r_ce;
    assign clk_o[k]     = r_clk;
    assign pending_o[k] = r_pend;
  end

endmodule

// File: tb/tb_hp300_cegen.sv
// Directed self-checking bench for hp300_cegen (NCH=2, DIVW=8, DIV_INIT={1,0}).
module tb_hp300_cegen;
  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  en_i;
  logic [15:0] div_i;
  logic [1:0]  div_load_i;
  logic        sync_i;
  logic [1:0]  ce_o, clk_o, pending_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  hp300_cegen dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .div_i(div_i),
    .div_load_i(div_load_i), .sync_i(sync_i), .ce_o(ce_o), .clk_o(clk_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    n++;
  endtask

  initial begin
    reset_n_i = 1'b0; en_i = 2'b11; div_i = 16'h0000; div_load_i = 2'b00; sync_i = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ce", ce_o[k], 1'b0);
      check_eq("rst_clk", clk_o[k], 1'b0);
      check_eq("rst_pend", pending_o[k], 1'b0);
    end
    reset_n_i = 1'b1;

    // Defaults: ch0 D=0 every cycle, ch1 D=1 every 2nd cycle
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("def_ce0", ce_o[0], 1'b1);
      check_eq("def_clk0", clk_o[0], (n % 2) == 1);
      check_eq("def_ce1", ce_o[1], (n % 2) == 0);
      check_eq("def_clk1", clk_o[1], ((n % 4) == 2) || ((n % 4) == 3));
    end

    // Load D=3 on ch0 coinciding with its wrap: immediate
    for (int i = 9; i <= 16; i++) begin
      if (i == 9) begin div_i = 16'h0003; div_load_i = 2'b01; end
      tick();
      div_load_i = 2'b00;
      check_eq("ld0_pend", pending_o[0], 1'b0);
      check_eq("ld0_ce0", ce_o[0], (n == 9) || (n == 13));
      check_eq("ld0_clk0", clk_o[0], n < 13);
      check_eq("ld0_ce1", ce_o[1], (n % 2) == 0);
      check_eq("ld0_clk1", clk_o[1], ((n % 4) == 2) || ((n % 4) == 3));
    end

    // Disabled load of D=9 on ch1 goes straight to act
    en_i = 2'b01; div_i = 16'h0900; div_load_i = 2'b10;
    tick();
    div_load_i = 2'b00; en_i = 2'b11;
    check_eq("dis_ld_pend", pending_o[1], 1'b0);
    check_eq("dis_ld_ce1", ce_o[1], 1'b0);
    for (int i = 18; i <= 21; i++) tick();

    // ch1 at cnt=4 of D=9, load D=2: pending until the wrap at edge 27
    for (int i = 22; i <= 33; i++) begin
      if (i == 22) begin div_i = 16'h0200; div_load_i = 2'b10; end
      tick();
      div_load_i = 2'b00;
      check_eq("pend1", pending_o[1], (n >= 22) && (n <= 26));
      check_eq("pend_ce1", ce_o[1], (n == 27) || (n == 30) || (n == 33));
      check_eq("pend_clk1", clk_o[1], ((n >= 27) && (n < 30)) || (n >= 33));
      check_eq("pend_ce0", ce_o[0], (n % 4) == 1);
    end

    // Bring ch1 to D=5, then leave D=7 pending and hit sync
    div_i = 16'h0500; div_load_i = 2'b10;
    tick();
    div_load_i = 2'b00;
    tick(); tick();
    check_eq("d5_ce1", ce_o[1], 1'b1);
    check_eq("d5_pend1", pending_o[1], 1'b0);
    div_i = 16'h0700; div_load_i = 2'b10;
    tick();
    div_load_i = 2'b00;
    check_eq("d7_pend1", pending_o[1], 1'b1);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq("sync_clk", clk_o[k], 1'b0);
      check_eq("sync_ce", ce_o[k], 1'b0);
      check_eq("sync_pend", pending_o[k], 1'b0);
    end
    for (int i = 39; i <= 46; i++) begin
      tick();
      check_eq("post_sync_ce0", ce_o[0], (n == 42) || (n == 46));
      check_eq("post_sync_ce1", ce_o[1], n == 46);
    end

    // ch1 disabled for 6 edges mid-period
    for (int i = 47; i <= 60; i++) begin
      en_i = ((i >= 49) && (i <= 54)) ? 2'b01 : 2'b11;
      tick();
      check_eq("hold_ce1", ce_o[1], n == 60);
      check_eq("hold_clk1", clk_o[1], n < 60);
      check_eq("hold_ce0", ce_o[0], ((n - 42) % 4) == 0);
    end
    en_i = 2'b11;

    // Leave a pending divisor, then pulse reset between edges
    div_i = 16'h0300; div_load_i = 2'b10;
    tick();
    div_load_i = 2'b00;
    check_eq("pre_rst_pend1", pending_o[1], 1'b1);
    check_eq("pre_rst_clk0", clk_o[0], 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("arst_ce", ce_o[k], 1'b0);
      check_eq("arst_clk", clk_o[k], 1'b0);
      check_eq("arst_pend", pending_o[k], 1'b0);
    end
    #1 reset_n_i = 1'b1;

    // After release the DIV_INIT divisors are back
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("re_ce0", ce_o[0], 1'b1);
      check_eq("re_clk0", clk_o[0], (n % 2) == 1);
      check_eq("re_ce1", ce_o[1], (n % 2) == 0);
      check_eq("re_clk1", clk_o[1], ((n % 4) == 2) || ((n % 4) == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hp300_cegen.md
HP300_CEGEN -- requirements
Module: hp300_cegen

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIVW, default 8: divisor width per channel.
REQ-003 SHALL have parameter DIV_INIT, width NCH*DIVW, default {8'd1, 8'd0}: per-channel divisor after reset; channel k uses slice [k*DIVW +: DIVW].
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en_i, input, NCH bits: per-channel run enable.
REQ-007 SHALL have port div_i, input, NCH*DIVW bits: new divisor value D per channel.
REQ-008 SHALL have port div_load_i, input, NCH bits: per-channel strobe that captures the channel's div_i slice.
REQ-009 SHALL have port sync_i, input, 1 bit: global phase-realign strobe.
REQ-010 SHALL have port ce_o, output, NCH bits: one-cycle clock-enable pulse per channel.
REQ-011 SHALL have port clk_o, output, NCH bits: divided square wave per channel.
REQ-012 SHALL have port pending_o, output, NCH bits: a captured divisor is waiting to take effect.

Function
REQ-013 SHALL give each channel a DIVW-bit counter cnt, an active divisor act, a shadow divisor shd and a pending flag.
REQ-014 SHALL treat act = D as a period of D+1 enabled cycles; D=0 SHALL give ce_o high on every enabled cycle.
REQ-015 SHALL wrap on any edge with en_i[k]=1 and cnt==act: cnt<=0, ce_o[k]<=1, clk_o[k]<=~clk_o[k].
REQ-016 SHALL apply these updates on any other edge with en_i[k]=1: cnt<=cnt+1, ce_o[k]<=0.
REQ-017 SHALL make clk_o[k] exactly 50% duty with period 2*(act+1) cycles.
REQ-018 SHALL register all outputs, with no combinational path from any input to any output.
REQ-019 SHALL, when en_i[k]=0, hold cnt and clk_o[k], and drive ce_o[k]<=0.
REQ-020 SHALL, on div_load_i[k]=1, set shd<=div_i slice and pending_o[k]<=1; a later load before application overwrites shd (last wins).
REQ-021 SHALL apply a pending divisor at the next wrap edge: act<=shd, pending_o[k]<=0. The wrap itself SHALL use the old act.
REQ-022 SHALL, when a load and a wrap occur on the same edge, write div_i directly into act and leave pending_o[k]=0.
REQ-023 SHALL, when a load arrives while en_i[k]=0, write div_i into act on that edge with pending_o[k]=0.
REQ-024 SHALL, on an edge with sync_i=1, do the following for all channels regardless of en_i: cnt<=0, ce_o<=0, clk_o<=0; a pending shd is applied to act and its pending flag cleared.
REQ-025 SHALL give sync_i priority over wrap and increment; a div_load_i on the same edge SHALL write act directly.
REQ-026 SHALL, if act is lowered below the current cnt (only possible through REQ-023), let cnt increment modulo 2^DIVW until it equals act; no error indication.

Reset
REQ-027 SHALL, while reset_n_i=0, asynchronously force cnt=0, ce_o=0, clk_o=0, pending_o=0, and act=shd=DIV_INIT.
REQ-028 SHALL, on reset assertion mid-period, clear all state immediately. After release, the first wrap of channel k SHALL occur on the (DIV_INIT_k+1)-th enabled edge.

Verification
REQ-029 Defaults, en_i=2'b11 held from release: ce_o[0] high every cycle from the 1st edge; clk_o[0] toggles every cycle; ce_o[1] high every 2nd cycle; clk_o[1] period 4.
REQ-030 Channel 0 loaded with D=3 while running at D=0: pending_o[0] stays low; period becomes 4 immediately; clk_o[0] period 8.
REQ-031 Channel 1 at D=9, cnt=4, loaded with D=2: pending_o[1]=1 for 5 cycles; one more 10-cycle period completes, then 3-cycle periods; pending_o[1] clears at that wrap.
REQ-032 Channel 0 at D=3 and channel 1 at D=5, sync_i pulsed with a pending load of 7 on channel 1: both clk_o read 0; the next ce_o[0] comes 4 edges later and the next ce_o[1] 8 edges later; pending_o=0.
REQ-033 en_i[1] dropped for 6 cycles mid-period: ce_o[1]=0 and clk_o[1] frozen throughout; after re-enable, the period resumes from the held cnt.
REQ-034 reset_n_i pulsed low asynchronously between edges: all outputs are 0 before the next edge, and act is back to DIV_INIT.
